// File: rtl/issue_scoreboard.sv
// Issue scoreboard between ID and EXE: per-register pending-write counters gate RAW/WAW hazards.
// Optional SB_PERF_EN adds stall_cycles/issue_count performance counters with a perf_clr input.
module issue_scoreboard #(
    parameter int NREG  = 32,
    parameter int IDX_W = 5,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left_valid,
    output logic             left_ready,
    input  logic [IDX_W-1:0] rs1_idx,
    input  logic             rs1_use,
    input  logic [IDX_W-1:0] rs2_idx,
    input  logic             rs2_use,
    input  logic [IDX_W-1:0] wreg_index,
    input  logic             wreg_en,
    output logic             right_valid,
    input  logic             right_ready,
    input  logic             wb_valid,
    input  logic [IDX_W-1:0] wb_index,
    input  logic             flush,
    output logic             hazard,
    output logic             sb_err
`ifdef SB_PERF_EN
    ,
    input  logic             perf_clr,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      issue_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [NREG];
    logic             rs1_busy;
    logic             rs2_busy;
    logic             wr_sat;
    logic             issue;
    logic             wb_err;
    logic [NREG-1:0]  inc_vec;
    logic [NREG-1:0]  dec_vec;

    // Saturated destination counters also stall, so a counter can never wrap.
    always_comb begin
        rs1_busy    = rs1_use && (rs1_idx != '0) && (cnt[rs1_idx] != '0);
        rs2_busy    = rs2_use && (rs2_idx != '0) && (cnt[rs2_idx] != '0);
        wr_sat      = wreg_en && (wreg_index != '0) && (cnt[wreg_index] == CNT_MAX);
        hazard      = rs1_busy | rs2_busy | wr_sat;
        right_valid = left_valid & ~hazard & ~flush;
        left_ready  = right_ready & ~hazard & ~flush;
        issue       = right_valid & right_ready;
        wb_err      = wb_valid && (wb_index != '0) && (cnt[wb_index] == '0);
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_vec[r] = issue && wreg_en && (wreg_index == IDX_W'(r));
            dec_vec[r] = wb_valid && (wb_index == IDX_W'(r)) && (cnt[r] != '0);
        end
    end

    // Issue and retire to the same register in one cycle cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            sb_err <= 1'b0;
        end else if (flush) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                case ({inc_vec[r], dec_vec[r]})
                    2'b10:   cnt[r] <= cnt[r] + CNT_W'(1);
                    2'b01:   cnt[r] <= cnt[r] - CNT_W'(1);
                    default: cnt[r] <= cnt[r];
                endcase
            end
            if (wb_err) begin
                sb_err <= 1'b1;
            end
        end
    end

`ifdef SB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            issue_count  <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
            issue_count  <= '0;
        end else begin
            if (left_valid && hazard && !flush) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (issue) begin
                issue_count <= issue_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus randomized traffic
// compared against an array-of-counts reference model.
module tb_issue_scoreboard;

    localparam int NREG    = 32;
    localparam int IDX_W   = 5;
    localparam int CNT_MAX = 3;

    logic             clk;
    logic             reset;
    logic             left_valid;
    logic             left_ready;
    logic [IDX_W-1:0] rs1_idx;
    logic             rs1_use;
    logic [IDX_W-1:0] rs2_idx;
    logic             rs2_use;
    logic [IDX_W-1:0] wreg_index;
    logic             wreg_en;
    logic             right_valid;
    logic             right_ready;
    logic             wb_valid;
    logic [IDX_W-1:0] wb_index;
    logic             flush;
    logic             hazard;
    logic             sb_err;
`ifdef SB_PERF_EN
    logic             perf_clr;
    logic [31:0]      stall_cycles;
    logic [31:0]      issue_count;
    int unsigned      model_stall;
    int unsigned      model_issue;
`endif

    int  checks;
    int  failures;
    int  model_cnt [NREG];
    bit  model_err;
    bit  allow_bad_wb;
    logic seen_hazard;
    logic seen_rv;

    issue_scoreboard #(.NREG(NREG), .IDX_W(IDX_W), .CNT_W(2)) dut (
        .clk(clk),
        .reset(reset),
        .left_valid(left_valid),
        .left_ready(left_ready),
        .rs1_idx(rs1_idx),
        .rs1_use(rs1_use),
        .rs2_idx(rs2_idx),
        .rs2_use(rs2_use),
        .wreg_index(wreg_index),
        .wreg_en(wreg_en),
        .right_valid(right_valid),
        .right_ready(right_ready),
        .wb_valid(wb_valid),
        .wb_index(wb_index),
        .flush(flush),
        .hazard(hazard),
        .sb_err(sb_err)
`ifdef SB_PERF_EN
        ,
        .perf_clr(perf_clr),
        .stall_cycles(stall_cycles),
        .issue_count(issue_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < NREG; r++) model_cnt[r] = 0;
        model_err = 1'b0;
`ifdef SB_PERF_EN
        model_stall = 0;
        model_issue = 0;
`endif
    endtask

    // Drives one cycle at the negedge, checks outputs against the model, then steps the model.
    task automatic apply_stimulus(input logic lv, input logic rr,
                                  input logic [IDX_W-1:0] r1, input logic u1,
                                  input logic [IDX_W-1:0] r2, input logic u2,
                                  input logic [IDX_W-1:0] wd, input logic wen,
                                  input logic wbv, input logic [IDX_W-1:0] wbi,
                                  input logic fl, input logic pclr);
        bit haz_e, rv_e, lr_e, iss_e, wb_ok, wb_bad;
        left_valid = lv; right_ready = rr;
        rs1_idx = r1; rs1_use = u1; rs2_idx = r2; rs2_use = u2;
        wreg_index = wd; wreg_en = wen;
        wb_valid = wbv; wb_index = wbi; flush = fl;
`ifdef SB_PERF_EN
        perf_clr = pclr;
`endif
        #1;
        haz_e = (u1 && r1 != 0 && model_cnt[r1] != 0) ||
                (u2 && r2 != 0 && model_cnt[r2] != 0) ||
                (wen && wd != 0 && model_cnt[wd] == CNT_MAX);
        rv_e  = lv && !haz_e && !fl;
        lr_e  = rr && !haz_e && !fl;
        iss_e = rv_e && rr;
        check_output("hazard", {31'd0, hazard}, {31'd0, haz_e});
        check_output("right_valid", {31'd0, right_valid}, {31'd0, rv_e});
        check_output("left_ready", {31'd0, left_ready}, {31'd0, lr_e});
        check_output("sb_err", {31'd0, sb_err}, {31'd0, model_err});
`ifdef SB_PERF_EN
        check_output("stall_cycles", stall_cycles, model_stall);
        check_output("issue_count", issue_count, model_issue);
        if (pclr) begin
            model_stall = 0;
            model_issue = 0;
        end else begin
            if (lv && haz_e && !fl) model_stall++;
            if (iss_e) model_issue++;
        end
`endif
        seen_hazard = hazard;
        seen_rv     = right_valid;
        if (fl) begin
            for (int r = 0; r < NREG; r++) model_cnt[r] = 0;
        end else begin
            wb_ok  = wbv && wbi != 0 && model_cnt[wbi] > 0;
            wb_bad = wbv && wbi != 0 && model_cnt[wbi] == 0;
            if (iss_e && wen && wd != 0) model_cnt[wd]++;
            if (wb_ok) model_cnt[wbi]--;
            if (wb_bad) model_err = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic random_cycle();
        logic [IDX_W-1:0] wbi;
        logic wbv;
        int start;
        wbv = 1'b0;
        wbi = '0;
        if ($urandom_range(0, 99) < 45) begin
            if (allow_bad_wb && $urandom_range(0, 99) < 15) begin
                wbv = 1'b1;
                wbi = IDX_W'($urandom_range(0, 7));
            end else begin
                start = $urandom_range(1, 7);
                for (int k = 0; k < 7; k++) begin
                    if (!wbv && model_cnt[((start + k - 1) % 7) + 1] > 0) begin
                        wbv = 1'b1;
                        wbi = IDX_W'(((start + k - 1) % 7) + 1);
                    end
                end
            end
        end
        apply_stimulus($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 70,
                       IDX_W'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                       IDX_W'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                       IDX_W'($urandom_range(0, 7)), $urandom_range(0, 99) < 75,
                       wbv, wbi, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        allow_bad_wb = 1'b0;
        clear_model();
        reset = 1'b0;
        left_valid = 0; right_ready = 0; rs1_idx = 0; rs1_use = 0; rs2_idx = 0; rs2_use = 0;
        wreg_index = 0; wreg_en = 0; wb_valid = 0; wb_index = 0; flush = 0;
`ifdef SB_PERF_EN
        perf_clr = 0;
`endif
        repeat (2) @(negedge clk);
        check_output("reset_hazard", {31'd0, hazard}, 32'd0);
        check_output("reset_sb_err", {31'd0, sb_err}, 32'd0);
        reset = 1'b1;

        // RAW: producer x5, consumer waits until the cycle after writeback.
        apply_stimulus(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        check_output("raw_producer_rv", {31'd0, seen_rv}, 32'd1);
        apply_stimulus(1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
        check_output("raw_stall", {31'd0, seen_hazard}, 32'd1);
        apply_stimulus(1, 1, 5, 1, 0, 0, 6, 1, 1, 5, 0, 0);
        check_output("raw_no_bypass", {31'd0, seen_hazard}, 32'd1);
        apply_stimulus(1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
        check_output("raw_release", {31'd0, seen_rv}, 32'd1);
        apply_stimulus(0, 1, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0);

        // Saturation on x7.
        repeat (3) apply_stimulus(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        apply_stimulus(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        check_output("sat_stall", {31'd0, seen_hazard}, 32'd1);
        apply_stimulus(1, 1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0);
        apply_stimulus(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        check_output("sat_release", {31'd0, seen_rv}, 32'd1);
        repeat (3) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);

        // Issue and writeback to x9 in the same cycle.
        apply_stimulus(1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
        apply_stimulus(1, 1, 0, 0, 0, 0, 9, 1, 1, 9, 0, 0);
        apply_stimulus(1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("same_cycle_x9_busy", {31'd0, seen_hazard}, 32'd1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);

        // Stray writebacks: x0 ignored, x3 sets the sticky error.
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check_output("wb_x0_no_err", {31'd0, sb_err}, 32'd0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        idle_cycle();
        check_output("sb_err_sticky", {31'd0, sb_err}, 32'd1);

        // Flush with x2/x4/x6 pending.
        apply_stimulus(1, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
        apply_stimulus(1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
        apply_stimulus(1, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0);
        apply_stimulus(1, 1, 0, 0, 0, 0, 8, 1, 1, 2, 1, 0);
        check_output("flush_no_issue", {31'd0, seen_rv}, 32'd0);
        apply_stimulus(1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("flush_consumer", {31'd0, seen_rv}, 32'd1);

`ifdef SB_PERF_EN
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        apply_stimulus(1, 1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0);
        repeat (4) apply_stimulus(1, 0, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0, 1, 11, 0, 0);
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle_cycle();
        check_output("perf_clr_stall", stall_cycles, 32'd0);
        check_output("perf_clr_issue", issue_count, 32'd0);
`endif

        // Random traffic with only legal writebacks.
        for (int i = 0; i < 1200; i++) random_cycle();

        // Async reset in the middle of a stall.
        apply_stimulus(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        left_valid = 1; right_ready = 1; rs1_idx = 5; rs1_use = 1; wreg_en = 0; wb_valid = 0; flush = 0;
        #2;
        check_output("stall_before_reset", {31'd0, hazard}, 32'd1);
        reset = 1'b0;
        #1;
        check_output("async_hazard", {31'd0, hazard}, 32'd0);
        check_output("async_rv", {31'd0, right_valid}, 32'd1);
        check_output("async_sb_err", {31'd0, sb_err}, 32'd0);
        clear_model();
        @(negedge clk);
        reset = 1'b1;

        // Random traffic including stray writebacks.
        allow_bad_wb = 1'b1;
        for (int i = 0; i < 1200; i++) random_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
